alu_issue_sched: RTL

Two-lane-in, one-lane-out issue scheduler that shares a single `alu` instance between both issue slots of the 2-issue front end. It buffers ALU issue packets from lane 0 (older) and lane 1 (younger) in a small in-order queue and presents one packet per cycle to the ALU. Back-pressure toward issue is a single stall signal. The block sits between the issue/arbitration stage and `alu`. The downstream result buffer's ready gates each dispatch.

---
 rtl/aqua_pkg.sv | 30 +++
 rtl/fifo_2w1r.sv | 71 +++++++
 rtl/alu_issue_sched.sv | 58 +++++
 3 files changed

// File: rtl/aqua_pkg.sv
// Shared types for the ALU issue path.
// Holds the issue packet and scheduler sizing.
package aqua_pkg;

  localparam int ALU_SCHED_DEPTH = 4;
  localparam int ALU_SCHED_CNT_W = $clog2(ALU_SCHED_DEPTH) + 1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic        valid;
    logic        is_instr2;
    alu_op_t     op;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } alu_issue_t;

endpackage

// File: rtl/fifo_2w1r.sv
// Two-write / one-read circular buffer with occupancy.
// Second write lands after the first only when both are enabled.
module fifo_2w1r #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wen0,
  input  logic                   wen1,
  input  T                       wdata0,
  input  T                       wdata1,
  input  logic                   ren,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] waddr1;
  logic [CW-1:0] npush;
  logic          pop;

  // Lane-1 slot follows lane 0 only when lane 0 also writes.
  always_comb begin
    waddr1 = wptr + AW'(wen0);
    npush  = CW'(wen0) + CW'(wen1);
    pop    = ren && (count != '0) && !clr;
  end

  // Pointer and occupancy update; clear wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clr) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(npush);
      rptr  <= rptr + AW'(pop);
      count <= count + npush - CW'(pop);
    end
  end

  // Entry storage; unreset, masked by the empty state upstream.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (wen0) mem[wptr]   <= wdata0;
      if (wen1) mem[waddr1] <= wdata1;
    end
  end

  assign rdata = mem[rptr];

  a_count_max : assert property (
    @(posedge clk) disable iff (rst) count <= DEPTH_C);

  a_no_overwrite : assert property (
    @(posedge clk) disable iff (rst)
    clr || ((DEPTH_C - count) >= npush));

endmodule

// File: rtl/alu_issue_sched.sv
// Shares one ALU between two issue lanes via an in-order queue.
// Stall comes from registered occupancy only.
import aqua_pkg::*;

module alu_issue_sched #(
  parameter int DEPTH = ALU_SCHED_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  alu_issue_t             i_issue0,
  input  alu_issue_t             i_issue1,
  output logic                   o_stall,
  output alu_issue_t             o_alu_pkg,
  input  logic                   i_alu_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] count;
  logic          acc;
  logic          wen0;
  logic          wen1;
  alu_issue_t    head;

  // Accept gating; a lone lane-1 packet takes the lane-0 slot.
  always_comb begin
    o_stall = (DEPTH_C - count) < CW'(2);
    acc     = !o_stall && !i_flush;
    wen0    = acc && i_issue0.valid;
    wen1    = acc && i_issue1.valid;
  end

  fifo_2w1r #(
    .DEPTH (DEPTH),
    .T     (alu_issue_t)
  ) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (i_flush),
    .wen0   (wen0),
    .wen1   (wen1),
    .wdata0 (i_issue0),
    .wdata1 (i_issue1),
    .ren    (i_alu_ready),
    .rdata  (head),
    .count  (count)
  );

  // Empty queue presents an all-zero packet to the ALU.
  always_comb begin
    o_alu_pkg = (count != '0) ? head : '0;
    o_count   = count;
  end

endmodule
